// File: rtl/repack_frame_ctrl.sv
// repack_frame_ctrl
// Frame sequencer in front of a word repacker. It forwards one frame of
// source beats to the repacker, then zero-pads until the last partial
// output word is complete. It waits until every owed output beat has been
// popped, then pulses the repacker's synchronous clear.
//
// Ports
//   clk_i, srst_i          clock, synchronous active-high reset
//   start_i, cfg_beats_i   frame start and frame length in input beats
//   busy_o, done_o         frame in progress / one-cycle completion pulse
//   s_val_i/s_data_i/s_rdy_o     source beat handshake
//   rp_val_o/rp_data_o/rp_rdy_i  repacker input handshake
//   rp_srst_o              repacker synchronous clear
//   rp_out_val_i/rp_out_rdy_i    repacker output handshake (monitor only)
//   last_o                 marks the final output beat of the frame
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | forwarding source beats into the repacker
// PAD   | pushing zero beats until the partial output word completes
// DRAIN | waiting for all owed output beats to be popped
// CLR   | clearing the repacker, done_o pulse
module repack_frame_ctrl #(
   parameter int IN    = 3,
   parameter int OUT   = 8,
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  cfg_beats_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic              s_val_i,
   input  logic [W*IN-1:0]   s_data_i,
   output logic              s_rdy_o,
   output logic              rp_val_o,
   output logic [W*IN-1:0]   rp_data_o,
   input  logic              rp_rdy_i,
   output logic              rp_srst_o,
   input  logic              rp_out_val_i,
   input  logic              rp_out_rdy_i,
   output logic              last_o
);

   localparam int RW = $clog2(2*OUT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAD,
      ST_DRAIN,
      ST_CLR
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  beats_q;
   logic [CNT_W-1:0]  beat_cnt_q;
   logic [CNT_W-1:0]  exp_cnt_q;
   logic [CNT_W-1:0]  pop_cnt_q;
   logic [RW-1:0]     r_q;

   logic [RW-1:0]     r_sum;
   logic [RW-1:0]     r_next;
   logic              wrap;
   logic              push;
   logic              pop;
   logic              last_beat;
   logic              pop_last;

   // Residue of words sitting in the repacker's partial output word.
   // IN <= OUT guarantees at most one wrap per push.
   assign r_sum  = r_q + RW'(IN);
   assign wrap   = (r_sum >= RW'(OUT));
   assign r_next = wrap ? (r_sum - RW'(OUT)) : r_sum;

   // push is derived from the state directly so the output process does
   // not feed back into itself through rp_val_o.
   assign push = !srst_i && rp_rdy_i &&
                 (((state_q == ST_RUN) && s_val_i) || (state_q == ST_PAD));
   assign pop  = rp_out_val_i && rp_out_rdy_i;

   assign last_beat = (beat_cnt_q == (beats_q - CNT_W'(1)));
   assign pop_last  = pop && (pop_cnt_q == (exp_cnt_q - CNT_W'(1)));

   always_comb begin
      state_d   = state_q;
      s_rdy_o   = 1'b0;
      rp_val_o  = 1'b0;
      rp_data_o = '0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      last_o    = 1'b0;
      rp_srst_o = srst_i || (state_q == ST_CLR);
      if (!srst_i) begin
         busy_o = (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d = (cfg_beats_i == '0) ? ST_DRAIN : ST_RUN;
               end
            end
            ST_RUN: begin
               rp_val_o  = s_val_i;
               rp_data_o = s_data_i;
               s_rdy_o   = rp_rdy_i;
               if (push && last_beat) begin
                  state_d = (r_next == '0) ? ST_DRAIN : ST_PAD;
               end
            end
            ST_PAD: begin
               rp_val_o = 1'b1;
               if (push && wrap) begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               last_o = pop_last;
               if ((pop_cnt_q == exp_cnt_q) || pop_last) begin
                  state_d = ST_CLR;
               end
            end
            ST_CLR: begin
               done_o  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q    <= ST_IDLE;
         beats_q    <= '0;
         beat_cnt_q <= '0;
         exp_cnt_q  <= '0;
         pop_cnt_q  <= '0;
         r_q        <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE) begin
            if (start_i) begin
               beats_q    <= cfg_beats_i;
               beat_cnt_q <= '0;
               exp_cnt_q  <= '0;
               pop_cnt_q  <= '0;
               r_q        <= '0;
            end
         end else begin
            if (pop) begin
               pop_cnt_q <= pop_cnt_q + CNT_W'(1);
            end
            if (push) begin
               r_q <= r_next;
               if (wrap) begin
                  exp_cnt_q <= exp_cnt_q + CNT_W'(1);
               end
               if (state_q == ST_RUN) begin
                  beat_cnt_q <= beat_cnt_q + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_repack_frame_ctrl.sv
// Testbench for repack_frame_ctrl: a behavioural repacker model feeds a
// scoreboard of expected output beats; a monitor compares each pop.
module tb_repack_frame_ctrl;

   localparam int IN    = 3;
   localparam int OUT   = 8;
   localparam int W     = 8;
   localparam int CNT_W = 16;
   localparam int CAP   = 24;

   logic              clk_i = 1'b0;
   logic              srst_i = 1'b1;
   logic              start_i = 1'b0;
   logic [CNT_W-1:0]  cfg_beats_i = '0;
   logic              busy_o, done_o;
   logic              s_val_i = 1'b0;
   logic [W*IN-1:0]   s_data_i = '0;
   logic              s_rdy_o, rp_val_o;
   logic [W*IN-1:0]   rp_data_o;
   logic              rp_rdy_i = 1'b0;
   logic              rp_srst_o;
   logic              rp_out_val_i = 1'b0;
   logic              rp_out_rdy_i = 1'b0;
   logic              last_o;

   always #5 clk_i = ~clk_i;

   repack_frame_ctrl #(.IN(IN), .OUT(OUT), .W(W), .CNT_W(CNT_W)) dut (
      .clk_i        (clk_i),
      .srst_i       (srst_i),
      .start_i      (start_i),
      .cfg_beats_i  (cfg_beats_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .s_val_i      (s_val_i),
      .s_data_i     (s_data_i),
      .s_rdy_o      (s_rdy_o),
      .rp_val_o     (rp_val_o),
      .rp_data_o    (rp_data_o),
      .rp_rdy_i     (rp_rdy_i),
      .rp_srst_o    (rp_srst_o),
      .rp_out_val_i (rp_out_val_i),
      .rp_out_rdy_i (rp_out_rdy_i),
      .last_o       (last_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- repacker model ----------------
   logic [W-1:0]     mq[$];
   logic [W*OUT-1:0] m_out_data = '0;
   int rdy_pct  = 100;
   int ordy_pct = 100;
   int sval_pct = 100;
   int out_mode = 1;   // 0 hold low, 1 always ready, 2 random

   always @(negedge clk_i) begin
      logic            m_push, m_pop, m_clr;
      logic [W*IN-1:0] m_in;
      m_push = rp_val_o && rp_rdy_i;
      m_pop  = rp_out_val_i && rp_out_rdy_i;
      m_clr  = rp_srst_o;
      m_in   = rp_data_o;
      @(posedge clk_i);
      #1;
      if (m_clr) begin
         mq.delete();
      end else begin
         if (m_pop) for (int i = 0; i < OUT; i++) void'(mq.pop_front());
         if (m_push) for (int i = 0; i < IN; i++) mq.push_back(m_in[i*W +: W]);
      end
      rp_rdy_i     = (mq.size() <= CAP - IN) && ($urandom_range(99) < rdy_pct);
      rp_out_val_i = (mq.size() >= OUT);
      for (int i = 0; i < OUT; i++) m_out_data[i*W +: W] = (i < mq.size()) ? mq[i] : '0;
      rp_out_rdy_i = (out_mode == 0) ? 1'b0 :
                     (out_mode == 1) ? 1'b1 : ($urandom_range(99) < ordy_pct);
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct packed {
      logic [W*OUT-1:0] data;
      logic             last;
   } exp_t;
   exp_t expq[$];

   int done_cnt = 0, last_cnt = 0, pop_cnt = 0, push_cnt = 0, clr_cnt = 0;

   always @(negedge clk_i) begin
      exp_t e;
      if (done_o) done_cnt++;
      if (last_o) last_cnt++;
      if (rp_val_o && rp_rdy_i) push_cnt++;
      if (rp_srst_o && !srst_i) clr_cnt++;
      if (rp_out_val_i && rp_out_rdy_i) begin
         pop_cnt++;
         if (expq.size() == 0) begin
            chk("pop_scoreboard_nonempty", 64'(expq.size()), 64'd1);
         end else begin
            e = expq.pop_front();
            chk("out_data", m_out_data, e.data);
            chk("out_last", 64'(last_o), 64'(e.last));
         end
      end else if (last_o) begin
         chk("last_requires_pop", 64'(rp_out_val_i && rp_out_rdy_i), 64'd1);
      end
   end

   // ---------------- stimulus ----------------
   int wseq = 1;

   task automatic run_frame(input int n, input bit poke_start, input int hold);
      int total, nout, r, pads, b, cyc, d0, p0, q0, l0, c0;
      exp_t e;
      total = n * IN;
      nout  = (total + OUT - 1) / OUT;
      r     = total % OUT;
      pads  = (r == 0) ? 0 : (OUT - r + IN - 1) / IN;
      for (int k = 0; k < nout; k++) begin
         e.data = '0;
         for (int j = 0; j < OUT; j++)
            if (k*OUT + j < total) e.data[j*W +: W] = W'(wseq + k*OUT + j);
         e.last = (k == nout - 1);
         expq.push_back(e);
      end
      @(posedge clk_i); #1;
      d0 = done_cnt; p0 = push_cnt; q0 = pop_cnt; l0 = last_cnt; c0 = clr_cnt;
      start_i = 1'b1;
      cfg_beats_i = CNT_W'(n);
      @(negedge clk_i);
      chk("busy_before_start", 64'(busy_o), 64'd0);
      b = 0;
      cyc = 0;
      while (b < n && cyc < 5000) begin
         @(posedge clk_i); #1;
         cyc++;
         start_i = poke_start && ($urandom_range(3) == 0);
         cfg_beats_i = CNT_W'($urandom_range(40));
         s_val_i = ($urandom_range(99) < sval_pct);
         for (int j = 0; j < IN; j++) s_data_i[j*W +: W] = W'(wseq + b*IN + j);
         @(negedge clk_i);
         if (cyc == 1) chk("busy_after_start", 64'(busy_o), 64'd1);
         if (s_val_i && s_rdy_o) b++;
      end
      if (b < n) chk("source_timeout", 64'(b), 64'(n));
      @(posedge clk_i); #1;
      start_i = 1'b0;
      s_val_i = 1'b0;
      s_data_i = '0;
      if (hold > 0) begin
         cyc = 0;
         while ((push_cnt - p0) < n + pads && cyc < 500) begin
            @(posedge clk_i); #1;
            cyc++;
         end
         repeat (hold) @(posedge clk_i);
         @(negedge clk_i);
         chk("hold_busy", 64'(busy_o), 64'd1);
         chk("hold_no_done", 64'(done_cnt - d0), 64'd0);
         out_mode = 1;
         @(negedge clk_i);
         chk("hold_rel_c1_done", 64'(done_o), 64'd0);
         @(negedge clk_i);
         chk("hold_rel_c2_last", 64'(last_o), 64'd1);
         chk("hold_rel_c2_done", 64'(done_o), 64'd0);
         @(negedge clk_i);
         chk("hold_rel_c3_done", 64'(done_o), 64'd1);
         chk("hold_rel_c3_clr", 64'(rp_srst_o), 64'd1);
      end
      cyc = 0;
      while (done_cnt == d0 && cyc < 3000) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      chk("done_seen", 64'(done_cnt != d0), 64'd1);
      repeat (2) @(posedge clk_i);
      #1;
      chk("frame_done_pulses", 64'(done_cnt - d0), 64'd1);
      chk("frame_last_pulses", 64'(last_cnt - l0), 64'((nout > 0) ? 1 : 0));
      chk("frame_pops", 64'(pop_cnt - q0), 64'(nout));
      chk("frame_pushes", 64'(push_cnt - p0), 64'(n + pads));
      chk("frame_clears", 64'(clr_cnt - c0), 64'd1);
      chk("scoreboard_empty", 64'(expq.size()), 64'd0);
      chk("idle_after_frame", 64'(busy_o), 64'd0);
      wseq += total;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, cyc, d0;
      // reset with active-looking inputs: everything must stay idle
      srst_i = 1'b1;
      start_i = 1'b1;
      s_val_i = 1'b1;
      cfg_beats_i = 16'd5;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_s_rdy", 64'(s_rdy_o), 64'd0);
      chk("rst_rp_val", 64'(rp_val_o), 64'd0);
      chk("rst_rp_data", 64'(rp_data_o), 64'd0);
      chk("rst_last", 64'(last_o), 64'd0);
      chk("rst_rp_srst", 64'(rp_srst_o), 64'd1);
      @(posedge clk_i); #1;
      srst_i = 1'b0;
      start_i = 1'b0;
      s_val_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_idle", 64'(busy_o), 64'd0);
      chk("post_rst_no_clr", 64'(rp_srst_o), 64'd0);

      // full-rate 8-beat frame: 24 words, 3 outputs, no padding
      run_frame(8, 1'b0, 0);

      // 3-beat frame with words 1..9: 3 pad beats, 2 discarded zeros
      wseq = 1;
      run_frame(3, 1'b0, 0);

      // downstream held off after padding
      out_mode = 0;
      run_frame(3, 1'b0, 20);

      // zero-beat frame timing
      @(posedge clk_i); #1;
      start_i = 1'b1;
      cfg_beats_i = '0;
      @(negedge clk_i);
      chk("z_t_busy", 64'(busy_o), 64'd0);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(negedge clk_i);
      chk("z_t1_busy", 64'(busy_o), 64'd1);
      chk("z_t1_done", 64'(done_o), 64'd0);
      chk("z_t1_rp_val", 64'(rp_val_o), 64'd0);
      @(negedge clk_i);
      chk("z_t2_done", 64'(done_o), 64'd1);
      chk("z_t2_clr", 64'(rp_srst_o), 64'd1);
      @(negedge clk_i);
      chk("z_t3_busy", 64'(busy_o), 64'd0);
      chk("z_t3_done", 64'(done_o), 64'd0);

      // abort after 2 of 8 beats
      @(posedge clk_i); #1;
      d0 = done_cnt;
      start_i = 1'b1;
      cfg_beats_i = 16'd8;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      b = 0;
      cyc = 0;
      while (b < 2 && cyc < 200) begin
         s_val_i = 1'b1;
         for (int j = 0; j < IN; j++) s_data_i[j*W +: W] = W'(wseq + b*IN + j);
         @(negedge clk_i);
         if (s_val_i && s_rdy_o) b++;
         @(posedge clk_i); #1;
         cyc++;
      end
      chk("abort_beats_sent", 64'(b), 64'd2);
      srst_i = 1'b1;
      @(negedge clk_i);
      chk("abort_busy", 64'(busy_o), 64'd0);
      chk("abort_s_rdy", 64'(s_rdy_o), 64'd0);
      chk("abort_rp_val", 64'(rp_val_o), 64'd0);
      chk("abort_clr", 64'(rp_srst_o), 64'd1);
      chk("abort_done", 64'(done_o), 64'd0);
      @(posedge clk_i); #1;
      srst_i = 1'b0;
      s_val_i = 1'b0;
      @(negedge clk_i);
      chk("abort_idle", 64'(busy_o), 64'd0);
      @(posedge clk_i); #1;
      chk("abort_no_done_pulse", 64'(done_cnt - d0), 64'd0);
      wseq += 2 * IN;
      run_frame(8, 1'b0, 0);

      // random traffic
      out_mode = 2;
      for (int f = 0; f < 50; f++) begin
         rdy_pct  = $urandom_range(100, 20);
         ordy_pct = $urandom_range(100, 20);
         sval_pct = $urandom_range(100, 20);
         run_frame($urandom_range(40), 1'b1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/repack_frame_ctrl.md
# repack_frame_ctrl

Frame sequencer for one word repacker: passes IN-word beats from a pixel source into the repacker for one frame of a configured length. At end of frame it zero-pads until the last partial OUT-word output is complete, and waits until every expected output beat has been popped. It then pulses the repacker's synchronous clear so the next frame starts empty. It sits between the pixel source and the repacker and monitors the repacker's output handshake.

## Interface
- IN, 3, words per input beat; requires 1 ≤ IN ≤ OUT
- OUT, 8, words per repacker output beat
- W, 8, bits per word
- CNT_W, 16, width of beat counters
- clk_i  in  1  clock, all logic on rising edge
- srst_i  in  1  synchronous active-high reset
- start_i  in  1  begin a frame; sampled only in IDLE
- cfg_beats_i  in  CNT_W  input beats in frame; latched on accepted start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse in CLR
- s_val_i  in  1  source beat valid
- s_data_i  in  W*IN  source beat, word 0 in LSBs
- s_rdy_o  out  1  source beat accepted when s_val_i && s_rdy_o
- rp_val_o  out  1  to repacker in_val
- rp_data_o  out  W*IN  to repacker in_data
- rp_rdy_i  in  1  from repacker in_rdy
- rp_srst_o  out  1  to repacker srst
- rp_out_val_i  in  1  repacker out_val (monitor)
- rp_out_rdy_i  in  1  downstream out_rdy to repacker (monitor)
- last_o  out  1  marks final output beat of frame

## Operation
- push = rp_val_o && rp_rdy_i; pop = rp_out_val_i && rp_out_rdy_i.
- Registers: state, beats (latched cfg), beat_cnt, residue r (0..OUT-1), exp_cnt (outputs owed), pop_cnt.
- Residue update on every push: if r+IN ≥ OUT then r ← r+IN−OUT and exp_cnt++, else r ← r+IN.
- Since IN ≤ OUT, at most one wrap per push. Compute r+IN at $clog2(2*OUT) bits.
- pop_cnt increments on each pop while busy. Pops in IDLE are ignored.
- IDLE: outputs idle.
  - On start_i, latch cfg_beats_i and clear beat_cnt, r, exp_cnt and pop_cnt.
  - If cfg_beats_i = 0, go to DRAIN; else go to RUN.
- RUN: rp_val_o = s_val_i, rp_data_o = s_data_i, s_rdy_o = rp_rdy_i.
  - On a push, beat_cnt++.
  - On the push with beat_cnt = beats−1: if the updated r = 0, go to DRAIN; else go to PAD.
- PAD: rp_val_o = 1, rp_data_o = 0, s_rdy_o = 0.
  - On the push that wraps r, go to DRAIN.
- DRAIN: rp_val_o = 0, s_rdy_o = 0.
  - If pop_cnt = exp_cnt, or (pop && pop_cnt = exp_cnt−1), go to CLR.
- CLR (one cycle): rp_srst_o = 1 and done_o = 1, then go to IDLE.
  - The clear discards leftover pad words in the repacker.
- rp_srst_o = srst_i || state==CLR.
- last_o = (state==DRAIN) && pop && pop_cnt = exp_cnt−1. It is combinational, coincident with the final output beat.
- In IDLE, DRAIN and CLR: rp_data_o = 0.
- In RUN, rp_data_o passes s_data_i through regardless of s_val_i.
- start_i while busy has no effect.

## Timing
- Reset: srst_i high forces IDLE and clears all counters.
  - During reset: s_rdy_o = 0, rp_val_o = 0, rp_data_o = 0, busy_o = 0, done_o = 0, last_o = 0, rp_srst_o = 1.
  - srst_i mid-frame aborts the frame. The repacker is cleared in the same cycle, with no done_o.
- start_i accepted at cycle t: busy_o high from t+1, and RUN is active at t+1.
- Source path is combinational pass-through, zero added latency. Ready/valid are never registered.
- Pad beats are issued back-to-back whenever rp_rdy_i is high.
- Final pop at cycle t: last_o high at t, CLR at t+1 (done_o, rp_srst_o), IDLE at t+2.
- Earliest new start after done_o: the cycle after CLR (in IDLE).
- Zero-beat frame: start at t, DRAIN at t+1, CLR at t+2.

## Test plan
- IN=3, OUT=8, cfg_beats=8, no stalls -> 8 pushes, no PAD, 24 words out as 3 output beats, last_o on 3rd pop, done_o 1 cycle later.
- cfg_beats=3, source data words 1..9 -> 3 pad beats of zeros.
  - exp_cnt = 2; outputs are words 1..8, then word 9 followed by 7 zeros.
  - rp_srst_o pulses once, discarding 2 leftover zero words.
- cfg_beats=3, rp_out_rdy_i held low 20 cycles after last pad -> controller stays in DRAIN, busy_o high. It completes 2 cycles after rp_out_rdy_i rises and the last beat pops.
- cfg_beats=0 -> no pushes, done_o at start+2, rp_srst_o high the same cycle.
- srst_i asserted after 2 of 8 beats -> immediately IDLE, rp_srst_o high, no done_o. A following frame of 8 beats produces exactly 3 correct outputs.
- Random rp_rdy_i, s_val_i and rp_out_rdy_i over 50 frames with random cfg_beats 0..40 -> every frame emits ceil(beats*3/8) outputs with exactly one last_o and one done_o. Source data order is preserved, no beat is lost or duplicated, and start_i while busy is ignored.
